// File: rtl/ptmch_pkg.sv
// Shared types for the SPI-match trigger sequencer: FSM state encoding and channel indices.
package ptmch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_FIRE  = 3'd3,
        ST_DONE  = 3'd4
    } ptmch_state_e;

    localparam logic [2:0] CH_PRGEXCT = 3'd0;
    localparam logic [2:0] CH_RDSTAT  = 3'd1;
    localparam logic [2:0] CH_BLKERS  = 3'd2;
    localparam logic [2:0] CH_PDREAD  = 3'd3;
    localparam logic [2:0] CH_WRSTAT  = 3'd4;

    // Lowest set index wins when several sniffer channels rise together.
    function automatic logic [2:0] lowest_ch(input logic [4:0] v);
        logic [2:0] c;
        c = CH_PRGEXCT;
        if (v[0])      c = CH_PRGEXCT;
        else if (v[1]) c = CH_RDSTAT;
        else if (v[2]) c = CH_BLKERS;
        else if (v[3]) c = CH_PDREAD;
        else if (v[4]) c = CH_WRSTAT;
        return c;
    endfunction

endpackage

// File: rtl/ptmch_trg_seq_if.sv
// Bundles the sequencer's configuration, match-pulse inputs and trigger/status outputs.
interface ptmch_trg_seq_if #(
    parameter int P_CNT_W = 8,
    parameter int P_DLY_W = 16
);
    logic [4:0]         TRG_PLS;
    logic               ARM;
    logic [4:0]         CH_EN;
    logic [P_CNT_W-1:0] MATCH_CNT;
    logic [P_DLY_W-1:0] DLY_CNT;
    logic [P_CNT_W-1:0] PLS_WIDTH;
    logic               TRG_OUT;
    logic [2:0]         TRG_CH;
    logic [P_CNT_W-1:0] HIT_CNT;
    logic               BUSY;
    logic               DONE;

    modport slave (
        input  TRG_PLS, ARM, CH_EN, MATCH_CNT, DLY_CNT, PLS_WIDTH,
        output TRG_OUT, TRG_CH, HIT_CNT, BUSY, DONE
    );

    modport master (
        output TRG_PLS, ARM, CH_EN, MATCH_CNT, DLY_CNT, PLS_WIDTH,
        input  TRG_OUT, TRG_CH, HIT_CNT, BUSY, DONE
    );
endinterface

// File: rtl/ptmch_trg_edge.sv
// Rising-edge detect on the five match pulses, channel mask and lowest-index priority encode.
// Latency: hit/ch are combinational from the current pulse vs. its 1-cycle delayed copy.
// No backpressure; the delayed copy updates every cycle.
module ptmch_trg_edge
    import ptmch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] pls,
    input  logic [4:0] en,
    output logic       hit,
    output logic [2:0] ch
);

    logic [4:0] pls_d;
    logic [4:0] qual;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pls_d <= '0;
        end else begin
            pls_d <= pls;
        end
    end

    assign qual = pls & ~pls_d & en;
    assign hit  = |qual;
    assign ch   = lowest_ch(qual);

endmodule

// File: rtl/ptmch_trg_seq.sv
// Delayed trigger sequencer: counts masked TRG_PLS rises and fires TRG_OUT on the Nth hit.
// Latency: TRG_OUT rises DLY_CNT+1 cycles after the edge sampling the firing hit; all outputs registered.
// No backpressure; hits outside ARMED are dropped. Define PTMCH_TRG_REARM_EN for continuous re-arm.
module ptmch_trg_seq
    import ptmch_pkg::*;
#(
    parameter int P_CNT_W = 8,
    parameter int P_DLY_W = 16
) (
    input  logic            CLK160M,
    input  logic            RESET_N,
    ptmch_trg_seq_if.slave  bus
);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_ARMED = ST_ARMED;
    localparam logic [2:0] S_DELAY = ST_DELAY;
    localparam logic [2:0] S_FIRE  = ST_FIRE;
    localparam logic [2:0] S_DONE  = ST_DONE;

    localparam logic [P_CNT_W:0]   HIT_ONE = (P_CNT_W+1)'(1);
    localparam logic [P_CNT_W-1:0] CNT_ONE = P_CNT_W'(1);
    localparam logic [P_DLY_W-1:0] DLY_ONE = P_DLY_W'(1);

    logic [2:0]         state;
    logic [P_DLY_W-1:0] dly_cnt;
    logic [P_CNT_W-1:0] pls_cnt;
    logic               trg_out;
    logic [2:0]         trg_ch;
    logic [P_CNT_W-1:0] hit_cnt;
    logic               busy;
    logic               done;

    logic               hit;
    logic [2:0]         ch;
    logic [P_CNT_W:0]   hit_nxt;
    logic [P_CNT_W:0]   match_eff;
    logic [P_CNT_W-1:0] pls_load;

    ptmch_trg_edge u_edge (
        .clk   (CLK160M),
        .rst_n (RESET_N),
        .pls   (bus.TRG_PLS),
        .en    (bus.CH_EN),
        .hit   (hit),
        .ch    (ch)
    );

    // One extra bit so the compare cannot alias when hit_cnt is at its maximum.
    assign hit_nxt   = {1'b0, hit_cnt} + HIT_ONE;
    assign match_eff = (bus.MATCH_CNT == '0) ? HIT_ONE : {1'b0, bus.MATCH_CNT};
    assign pls_load  = (bus.PLS_WIDTH == '0) ? '0 : bus.PLS_WIDTH - CNT_ONE;

    always_ff @(posedge CLK160M or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= S_IDLE;
            dly_cnt <= '0;
            pls_cnt <= '0;
            trg_out <= 1'b0;
            trg_ch  <= '0;
            hit_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (!bus.ARM && state != S_IDLE) begin
            // Disarm aborts from any state; TRG_CH/HIT_CNT are kept for inspection.
            state   <= S_IDLE;
            trg_out <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.ARM) begin
                        state   <= S_ARMED;
                        hit_cnt <= '0;
                    end
                end
                S_ARMED: begin
                    if (hit) begin
                        hit_cnt <= hit_nxt[P_CNT_W-1:0];
                        if (hit_nxt >= match_eff) begin
                            trg_ch  <= ch;
                            dly_cnt <= bus.DLY_CNT;
                            busy    <= 1'b1;
                            state   <= S_DELAY;
                        end
                    end
                end
                S_DELAY: begin
                    if (dly_cnt == '0) begin
                        state   <= S_FIRE;
                        trg_out <= 1'b1;
                        pls_cnt <= pls_load;
                    end else begin
                        dly_cnt <= dly_cnt - DLY_ONE;
                    end
                end
                S_FIRE: begin
                    if (pls_cnt == '0) begin
                        trg_out <= 1'b0;
                        busy    <= 1'b0;
`ifdef PTMCH_TRG_REARM_EN
                        state   <= S_ARMED;
                        hit_cnt <= '0;
`else
                        state   <= S_DONE;
                        done    <= 1'b1;
`endif
                    end else begin
                        pls_cnt <= pls_cnt - CNT_ONE;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state   <= S_IDLE;
                    trg_out <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.TRG_OUT = trg_out;
    assign bus.TRG_CH  = trg_ch;
    assign bus.HIT_CNT = hit_cnt;
    assign bus.BUSY    = busy;
    assign bus.DONE    = done;

endmodule

// File: tb/tb_ptmch_trg_seq.sv
// Scoreboard bench for ptmch_trg_seq: a pulse-level model predicts each TRG_OUT pulse, a monitor checks them.
module tb_ptmch_trg_seq;

    logic CLK160M = 1'b0;
    logic RESET_N = 1'b0;
    always #3 CLK160M = ~CLK160M;

    ptmch_trg_seq_if bus ();

    ptmch_trg_seq dut (
        .CLK160M (CLK160M),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    typedef struct {
        int rise;
        int w;
        int ch;
        int hc;
    } exp_t;

    exp_t        exp_q[$];
    logic [4:0]  pats[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
`ifdef PTMCH_TRG_REARM_EN
    localparam bit ONE_SHOT = 1'b0;
`else
    localparam bit ONE_SHOT = 1'b1;
`endif

    always @(posedge CLK160M) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic int lowest(input logic [4:0] v);
        for (int i = 0; i < 5; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Monitor: every TRG_OUT pulse must match the oldest predicted pulse.
    initial begin : monitor
        logic prev;
        int   hi;
        int   ew;
        exp_t e;
        prev = 1'b0;
        hi   = 0;
        ew   = -1;
        forever begin
            @(negedge CLK160M);
            if (bus.TRG_OUT && !prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", exp_q.size(), 1);
                    ew = -1;
                end else begin
                    e = exp_q.pop_front();
                    chk("rise_cycle", cyc, e.rise);
                    chk("trg_ch", int'(bus.TRG_CH), e.ch);
                    chk("hit_cnt_at_fire", int'(bus.HIT_CNT), e.hc);
                    ew = e.w;
                end
                hi = 1;
            end else if (bus.TRG_OUT) begin
                hi++;
            end else if (prev && ew >= 0) begin
                chk("pulse_width", hi, ew);
            end
            if (bus.TRG_OUT) chk("busy_in_fire", int'(bus.BUSY), 1);
            prev = bus.TRG_OUT;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK160M);
    endtask

    task automatic arm_cfg(input int m, input int d, input int w, input logic [4:0] chen);
        @(negedge CLK160M);
        bus.ARM     = 1'b0;
        bus.TRG_PLS = '0;
        idle(2);
        bus.MATCH_CNT = 8'(m);
        bus.DLY_CNT   = 16'(d);
        bus.PLS_WIDTH = 8'(w);
        bus.CH_EN     = chen;
        bus.ARM       = 1'b1;
        idle(2);
        chk("hit_cnt_after_arm", int'(bus.HIT_CNT), 0);
        chk("busy_after_arm", int'(bus.BUSY), 0);
    endtask

    // Drives the patterns in pats[]; a hit is a masked rise sampled while the block is armed.
    task automatic run_trial(input int m, input int d, input int w, input logic [4:0] chen,
                             input int hold_fix, input int gap_fix);
        int   mm, wm, hits, busy_until, k, hold, gap, last_ch;
        bit   fired;
        logic [4:0] q;
        exp_t e;
        mm = (m == 0) ? 1 : m;
        wm = (w == 0) ? 1 : w;
        hits = 0; fired = 0; busy_until = -1; last_ch = 0;
        arm_cfg(m, d, w, chen);
        foreach (pats[i]) begin
            hold = (hold_fix != 0) ? hold_fix : int'($urandom_range(2, 4));
            gap  = (gap_fix  != 0) ? gap_fix  : int'($urandom_range(2, 5));
            bus.TRG_PLS = pats[i];
            k = cyc + 1;
            q = pats[i] & chen;
            if (q != 0 && k > busy_until) begin
                hits++;
                if (hits >= mm) begin
                    e.rise = k + d + 1; e.w = wm; e.ch = lowest(q); e.hc = hits;
                    exp_q.push_back(e);
                    fired = 1; last_ch = e.ch;
                    if (ONE_SHOT) busy_until = 1 << 30;
                    else begin busy_until = k + d + 1 + wm; hits = 0; end
                end
            end
            idle(hold);
            bus.TRG_PLS = '0;
            idle(gap);
            if (!fired) chk("hit_cnt_running", int'(bus.HIT_CNT), hits);
        end
        idle(d + wm + 8);
        chk("hit_cnt_final", int'(bus.HIT_CNT), hits);
        chk("done_final", int'(bus.DONE), (ONE_SHOT && fired) ? 1 : 0);
        chk("busy_final", int'(bus.BUSY), 0);
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        bus.ARM = 1'b0;
        idle(1);
        chk("done_after_disarm", int'(bus.DONE), 0);
        chk("trg_out_after_disarm", int'(bus.TRG_OUT), 0);
        chk("hit_cnt_kept", int'(bus.HIT_CNT), hits);
        if (fired) chk("trg_ch_kept", int'(bus.TRG_CH), last_ch);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stim
        int k, n;
        exp_t e;
        bus.TRG_PLS = '0; bus.ARM = 1'b0; bus.CH_EN = '0;
        bus.MATCH_CNT = '0; bus.DLY_CNT = '0; bus.PLS_WIDTH = '0;
        idle(3);
        chk("rst_trg_out", int'(bus.TRG_OUT), 0);
        chk("rst_trg_ch", int'(bus.TRG_CH), 0);
        chk("rst_hit_cnt", int'(bus.HIT_CNT), 0);
        chk("rst_busy", int'(bus.BUSY), 0);
        chk("rst_done", int'(bus.DONE), 0);
        RESET_N = 1'b1;
        idle(2);

        pats = '{5'h01};                 run_trial(1, 10, 4, 5'h01, 15, 3);
        pats = '{5'h08, 5'h08, 5'h08};   run_trial(3, 5, 2, 5'h08, 0, 0);
        pats = '{5'h14, 5'h02, 5'h14};   run_trial(2, 3, 3, 5'h1D, 0, 0);
        pats = '{5'h01};                 run_trial(0, 0, 0, 5'h1F, 0, 0);
`ifdef PTMCH_TRG_REARM_EN
        pats = '{5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01};
        run_trial(2, 3, 2, 5'h01, 2, 10);
`endif
        for (int t = 0; t < 40; t++) begin
            pats.delete();
            n = int'($urandom_range(1, 6));
            repeat (n) pats.push_back(5'($urandom_range(1, 31)));
            run_trial(int'($urandom_range(0, 4)), int'($urandom_range(0, 20)),
                      int'($urandom_range(0, 6)), 5'($urandom_range(1, 31)), 0, 0);
        end

        // Disarm while the delay is counting: no pulse may ever appear.
        arm_cfg(1, 10, 4, 5'h01);
        bus.TRG_PLS = 5'h01;
        idle(2);
        bus.TRG_PLS = '0;
        idle(2);
        bus.ARM = 1'b0;
        idle(1);
        chk("abort_delay_trg_out", int'(bus.TRG_OUT), 0);
        chk("abort_delay_busy", int'(bus.BUSY), 0);
        chk("abort_delay_hit_cnt", int'(bus.HIT_CNT), 1);
        idle(20);
        chk("abort_delay_queue", exp_q.size(), 0);

        // Reset while the pulse is high: truncated pulse, then clean re-arm from zero.
        arm_cfg(1, 2, 6, 5'h10);
        bus.TRG_PLS = 5'h10;
        k = cyc + 1;
        e.rise = k + 3; e.w = -1; e.ch = 4; e.hc = 1;
        exp_q.push_back(e);
        idle(2);
        bus.TRG_PLS = '0;
        while (cyc < k + 5) @(negedge CLK160M);
        chk("fire_before_reset", int'(bus.TRG_OUT), 1);
        #1 RESET_N = 1'b0;
        #1;
        chk("reset_fire_trg_out", int'(bus.TRG_OUT), 0);
        chk("reset_fire_busy", int'(bus.BUSY), 0);
        chk("reset_fire_hit_cnt", int'(bus.HIT_CNT), 0);
        chk("reset_fire_trg_ch", int'(bus.TRG_CH), 0);
        idle(2);
        RESET_N = 1'b1;
        idle(3);
        chk("rearm_hit_cnt", int'(bus.HIT_CNT), 0);
        chk("rearm_busy", int'(bus.BUSY), 0);
        idle(20);
        chk("reset_fire_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
